sha2_kw_sched: RTL and testbench

SHA2_KW_SCHED -- requirements
Module: sha2_kw_sched

---
 rtl/sha2_pkg.sv | 60 ++++++
 rtl/sha2_k_rom.sv | 30 +++
 rtl/sha2_kw_sched.sv | 105 ++++++++++
 tb/tb_sha2_kw_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants: round counts, K tables for both word widths, the
// message-schedule sigma functions and the scheduler FSM state type.
package sha2_pkg;

  localparam int ROUNDS32 = 64;
  localparam int ROUNDS64 = 80;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K32 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K64 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic logic [31:0] sig0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sig0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

endpackage

// File: rtl/sha2_k_rom.sv
// SHA-2 round-constant ROM with registered output; loads only when en is high
// so the presented constant holds while the consumer stalls.
module sha2_k_rom
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [6:0]        addr,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] rd;

  generate
    if (WORD_W == 32) begin : g_k32
      assign rd = addr[6] ? '0 : K32[addr[5:0]];
    end else begin : g_k64
      assign rd = (addr < 7'd80) ? K64[addr] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)   data <= '0;
    else if (en) data <= rd;
  end

endmodule

// File: rtl/sha2_kw_sched.sv
// SHA-2 message scheduler: streams (t, K_t, W_t) for one block with a
// valid/ready handshake. Macro SHA2_KW_SCHED_PRESUM_EN adds out_kw = K_t + W_t.
module sha2_kw_sched
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [16*WORD_W-1:0] blk_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           out_round,
  output logic [WORD_W-1:0]    out_k,
  output logic [WORD_W-1:0]    out_w,
`ifdef SHA2_KW_SCHED_PRESUM_EN
  output logic [WORD_W-1:0]    out_kw,
`endif
  output logic                 out_last,
  output logic                 done
);

  localparam int ROUNDS = (WORD_W == 64) ? ROUNDS64 : ROUNDS32;

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $fatal(1, "sha2_kw_sched: WORD_W must be 32 or 64");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WORD_W-1:0] win [16];
  logic [WORD_W-1:0] s0, s1, w_new;
  logic              xfer, start_acc, last_round, rom_en;
  logic [6:0]        rom_addr;

  assign busy       = (state_q == RUN);
  assign out_valid  = busy;
  assign xfer       = out_valid & out_ready;
  assign start_acc  = (state_q == IDLE) & start;
  assign last_round = (out_round == 7'(ROUNDS - 1));
  assign out_last   = out_valid & last_round;
  assign out_w      = win[0];

  // win[k] holds W_{t+k}; the word entering at the top is W_{t+16}
  generate
    if (WORD_W == 32) begin : g_sig32
      assign s0 = sig0_32(win[1]);
      assign s1 = sig1_32(win[14]);
    end else begin : g_sig64
      assign s0 = sig0_64(win[1]);
      assign s1 = sig1_64(win[14]);
    end
  endgenerate

  assign w_new = s1 + win[9] + s0 + win[0];

  // ROM is addressed one round ahead so K_t lands with W_t
  assign rom_en   = start_acc | (xfer & ~last_round);
  assign rom_addr = start_acc ? 7'd0 : out_round + 7'd1;

  sha2_k_rom #(.WORD_W(WORD_W)) u_k_rom (
    .clk   (clk),
    .reset (reset),
    .en    (rom_en),
    .addr  (rom_addr),
    .data  (out_k)
  );

`ifdef SHA2_KW_SCHED_PRESUM_EN
  assign out_kw = out_k + out_w;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (xfer && last_round) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      done      <= 1'b0;
      out_round <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state_q <= state_d;
      done    <= xfer & last_round;
      if (start_acc) begin
        out_round <= '0;
        for (int i = 0; i < 16; i++) win[i] <= blk_in[(15-i)*WORD_W +: WORD_W];
      end else if (xfer) begin
        if (!last_round) out_round <= out_round + 7'd1;
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_sha2_kw_sched.sv
// Directed bench for sha2_kw_sched: 32- and 64-bit instances driven with the
// "abc" padded block, plus stall, ignored-start, back-to-back and reset cases.
module tb_sha2_kw_sched;

  logic          clk = 1'b0;
  logic          reset;
  logic          start32, rdy32, start64, rdy64;
  logic [511:0]  blk32;
  logic [1023:0] blk64;

  logic          busy32, valid32, last32, done32;
  logic [6:0]    round32;
  logic [31:0]   k32, w32;
  logic          busy64, valid64, last64, done64;
  logic [6:0]    round64;
  logic [63:0]   k64, w64;
`ifdef SHA2_KW_SCHED_PRESUM_EN
  logic [31:0]   kw32;
  logic [63:0]   kw64;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sha2_kw_sched #(.WORD_W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .blk_in(blk32),
    .busy(busy32), .out_valid(valid32), .out_ready(rdy32), .out_round(round32),
    .out_k(k32), .out_w(w32),
`ifdef SHA2_KW_SCHED_PRESUM_EN
    .out_kw(kw32),
`endif
    .out_last(last32), .done(done32)
  );

  sha2_kw_sched #(.WORD_W(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .blk_in(blk64),
    .busy(busy64), .out_valid(valid64), .out_ready(rdy64), .out_round(round64),
    .out_k(k64), .out_w(w64),
`ifdef SHA2_KW_SCHED_PRESUM_EN
    .out_kw(kw64),
`endif
    .out_last(last64), .done(done64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start32 = 1'b0; rdy32 = 1'b0; start64 = 1'b0; rdy64 = 1'b0;
    blk32 = '0; blk32[511:480] = 32'h61626380; blk32[31:0] = 32'h18;
    blk64 = '0; blk64[1023:960] = 64'h6162638000000000; blk64[63:0] = 64'h18;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_busy32", busy32, 0);   chk("rst_valid32", valid32, 0);
    chk("rst_done32", done32, 0);   chk("rst_last32", last32, 0);
    chk("rst_round32", round32, 0); chk("rst_k32", k32, 0);
    chk("rst_w32", w32, 0);
    chk("rst_valid64", valid64, 0); chk("rst_k64", k64, 0);
    chk("rst_w64", w64, 0);
`ifdef SHA2_KW_SCHED_PRESUM_EN
    chk("rst_kw32", kw32, 0);
`endif

    // full 32-bit block with the consumer always ready
    rdy32 = 1'b1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int t = 0; t < 64; t++) begin
      chk("a_valid", valid32, 1);
      chk("a_round", round32, 64'(t));
      chk("a_last", last32, 64'(t == 63));
      chk("a_busy", busy32, 1);
      if (t == 0)  begin chk("a_w0", w32, 32'h61626380); chk("a_k0", k32, 32'h428a2f98); end
      if (t == 15) chk("a_w15", w32, 32'h18);
      if (t == 16) chk("a_w16", w32, 32'h61626380);
      if (t == 17) chk("a_w17", w32, 32'h000f0000);
      if (t == 63) chk("a_k63", k32, 32'hc67178f2);
`ifdef SHA2_KW_SCHED_PRESUM_EN
      chk("a_kw_sum", kw32, 64'(32'(k32 + w32)));
      if (t == 0)  chk("a_kw0", kw32, 32'ha3ec9318);
      if (t == 16) chk("a_kw16", kw32, 32'h45fdcd41);
      if (t == 17) chk("a_kw17", kw32, 32'hefcd4786);
`endif
      @(negedge clk);
    end
    chk("a_done", done32, 1);
    chk("a_done_busy", busy32, 0);
    chk("a_done_valid", valid32, 0);

    // start in the done cycle is accepted
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("b2b_done_drop", done32, 0);
    chk("b2b_valid", valid32, 1);
    chk("b2b_round", round32, 0);
    chk("b2b_w0", w32, 32'h61626380);
    chk("b2b_k0", k32, 32'h428a2f98);
    repeat (3) @(negedge clk);
    chk("stall_at3", round32, 3);

    // consumer stall at round 3
    rdy32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_round", round32, 3);
      chk("stall_k", k32, 32'he9b5dba5);
      chk("stall_w", w32, 0);
      chk("stall_valid", valid32, 1);
    end
    rdy32 = 1'b1;
    @(negedge clk);
    chk("resume_round", round32, 4);
    chk("resume_k", k32, 32'h3956c25b);

    // start while busy is ignored
    repeat (6) @(negedge clk);
    chk("busy_start_at10", round32, 10);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("busy_start_round", round32, 11);
    chk("busy_start_k", k32, 32'h550c7dc3);
    @(negedge clk);
    chk("busy_start_round12", round32, 12);
    chk("busy_start_k12", k32, 32'h72be5d74);

    // reset at round 20 with a coincident start
    repeat (8) @(negedge clk);
    chk("mid_rst_at20", round32, 20);
    chk("mid_rst_k20", k32, 32'h2de92c6f);
    reset = 1'b1; start32 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start32 = 1'b0;
    chk("mid_rst_valid", valid32, 0);
    chk("mid_rst_busy", busy32, 0);
    chk("mid_rst_done", done32, 0);
    chk("mid_rst_round", round32, 0);
    chk("mid_rst_w", w32, 0);
    @(negedge clk);
    chk("mid_rst_done2", done32, 0);
    chk("mid_rst_valid2", valid32, 0);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("post_rst_valid", valid32, 1);
    chk("post_rst_round", round32, 0);
    chk("post_rst_w0", w32, 32'h61626380);
    chk("post_rst_k0", k32, 32'h428a2f98);
    rdy32 = 1'b0;

    // full 64-bit block
    rdy64 = 1'b1; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    for (int t = 0; t < 80; t++) begin
      chk("d_valid", valid64, 1);
      chk("d_round", round64, 64'(t));
      chk("d_last", last64, 64'(t == 79));
      if (t == 0)  begin chk("d_w0", w64, 64'h6162638000000000); chk("d_k0", k64, 64'h428a2f98d728ae22); end
      if (t == 1)  chk("d_k1", k64, 64'h7137449123ef65cd);
      if (t == 15) chk("d_w15", w64, 64'h18);
      if (t == 16) chk("d_w16", w64, 64'h6162638000000000);
      if (t == 17) chk("d_w17", w64, 64'h00030000000000c0);
      if (t == 79) chk("d_k79", k64, 64'h6c44198c4a475817);
`ifdef SHA2_KW_SCHED_PRESUM_EN
      if (t == 0) chk("d_kw0", kw64, 64'ha3ec9318d728ae22);
`endif
      @(negedge clk);
    end
    chk("d_done", done64, 1);
    chk("d_done_busy", busy64, 0);
    chk("d_done_valid", valid64, 0);
    @(negedge clk);
    chk("d_done_pulse", done64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
